// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: start/pattern request and serial output bundle of the pattern transmitter
interface seq_pattern_gen_if #(
  parameter int WIDTH = 6,
  parameter int LENW  = 3,
  parameter int REPW  = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LENW-1:0]  len;
  logic [REPW-1:0]  reps;
  logic             busy;
  logic             dout;
  logic             dout_valid;
  logic             done;
  modport master (output start, pattern, len, reps, input busy, dout, dout_valid, done);
  modport slave  (input start, pattern, len, reps, output busy, dout, dout_valid, done);
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter, MSB first, repeated with optional idle gap.
// Define SEQ_PATTERN_GEN_PARITY_EN to append an even-parity bit to every repetition.
module seq_pattern_gen #(
  parameter int WIDTH = 6,
  parameter int LENW  = 3,
  parameter int REPW  = 4,
  parameter int GAP   = 0
) (
  input logic          clk_i,
  input logic          rst_ni,
  seq_pattern_gen_if.slave bus
);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_PAR, S_GAP, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
`endif
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [LENW-1:0] WMAX = LENW'(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LENW-1:0]  len_q, len_d, idx_q, idx_d;
  logic [REPW-1:0]  rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             busy_q, busy_d, dout_q, dout_d, dv_q, dv_d, done_q, done_d;
  logic             rep_end;
  logic [LENW-1:0]  len_eff;
  assign len_eff = bus.len > WMAX ? WMAX : bus.len;
  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.done       = done_q;
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    rep_end = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start && bus.len != '0) begin
        // bits above the active field are cleared so parity can fold the whole register
        pat_d   = bus.pattern & ~({WIDTH{1'b1}} << len_eff);
        len_d   = len_eff;
        rep_d   = bus.reps == '0 ? REPW'(1) : bus.reps;
        idx_d   = len_eff - 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        idx_d = idx_q == '0 ? idx_q : idx_q - 1'b1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        state_d = idx_q == '0 ? S_PAR : S_SEND;
`else
        rep_end = idx_q == '0;
`endif
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      S_PAR: rep_end = 1'b1;
`endif
      S_GAP: begin
        state_d = gap_q == '0 ? S_SEND : S_GAP;
        idx_d   = gap_q == '0 ? len_q - 1'b1 : idx_q;
        gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rep_end) begin
      rep_d = rep_q - 1'b1;
      if (rep_q > REPW'(1)) begin
        state_d = GAP > 0 ? S_GAP : S_SEND;
        gap_d   = GW'(GAP - 1);
        idx_d   = len_q - 1'b1;
      end else begin
        state_d = S_DONE;
      end
    end
    dv_d   = state_q == S_SEND;
    dout_d = state_q == S_SEND && pat_q[idx_q];
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    if (state_q == S_PAR) begin
      dv_d   = 1'b1;
      dout_d = ^pat_q;
    end
`endif
    done_d = state_q == S_DONE;
    busy_d = state_d != S_IDLE || done_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: two transmitters (gap 0 and gap 2) driven in lockstep and checked
// every cycle against a timeline model, plus literal frame checks on the gap-0 stream.
module tb_seq_pattern_gen;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0;
  logic [5:0] pattern = '0;
  logic [2:0] len = '0;
  logic [3:0] reps = '0;
  int vectors = 0, miscompares = 0;
  seq_pattern_gen_if ia ();
  seq_pattern_gen_if ib ();
  assign ia.start = start;
  assign ia.pattern = pattern;
  assign ia.len = len;
  assign ia.reps = reps;
  assign ib.start = start;
  assign ib.pattern = pattern;
  assign ib.len = len;
  assign ib.reps = reps;
  seq_pattern_gen #(.GAP(0)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(ia));
  seq_pattern_gen #(.GAP(2)) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  // expected {busy,dout,dout_valid,done} s cycles after the accepting edge
  function automatic logic [3:0] exp_at(input int gap, input logic [5:0] pat, input int l,
                                        input int r, input int s);
    int per, cyc, total, o;
    logic [5:0] m;
    per = l + PB;
    cyc = per + gap;
    total = r * per + (r - 1) * gap;
    m = 6'((1 << l) - 1);
    if (s == 0) return 4'b1000;
    if (s - 1 == total) return 4'b1001;
    if (s - 1 > total) return 4'b0000;
    o = (s - 1) % cyc;
    if (o < l) return {1'b1, pat[l - 1 - o], 2'b10};
    if (o < per) return {1'b1, ^(pat & m), 2'b10};
    return 4'b1000;
  endfunction
  bit act[2] = '{0, 0};
  int step[2] = '{0, 0};
  logic [5:0] mp[2] = '{0, 0};
  int ml[2] = '{0, 0};
  int mr[2] = '{0, 0};
  logic [3:0] expv[2] = '{0, 0};
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 0;
        expv[i] = 4'b0;
      end else begin
        if (act[i]) step[i]++;
        else if (start && len != 3'd0) begin
          act[i] = 1;
          step[i] = 0;
          mp[i] = pattern;
          ml[i] = len > 3'd6 ? 6 : int'(len);
          mr[i] = reps == 4'd0 ? 1 : int'(reps);
        end
        expv[i] = act[i] ? exp_at(2 * i, mp[i], ml[i], mr[i], step[i]) : 4'b0;
        if (expv[i][0]) act[i] = 0;
      end
    end
  end
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    chk($sformatf("cyc%0d_gap0", cyc), {28'd0, ia.busy, ia.dout, ia.dout_valid, ia.done}, {28'd0, expv[0]});
    chk($sformatf("cyc%0d_gap2", cyc), {28'd0, ib.busy, ib.dout, ib.dout_valid, ib.done}, {28'd0, expv[1]});
  end
  logic [31:0] col = '0;
  int nbits = 0, hits = 0, nb0 = 0, h0 = 0;
  always @(negedge clk) if (ia.dout_valid) begin
    col = {col[30:0], ia.dout};
    nbits++;
    if (nbits - nb0 >= 6 && col[5:0] == 6'b101010) hits++;
  end
  task automatic go(input logic [5:0] p, input logic [2:0] l, input logic [3:0] r);
    @(negedge clk);
    nb0 = nbits;
    h0 = hits;
    pattern = p;
    len = l;
    reps = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while ((ia.busy || ib.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_in_time"}, 32'(n < 400), 32'd1);
  endtask
  task automatic frame_chk(input string nm, input logic [31:0] want, input int n, input int h);
    chk({nm, "_nbits"}, 32'(nbits - nb0), 32'(n));
    chk({nm, "_bits"}, col & 32'((64'd1 << n) - 1), want);
    chk({nm, "_hits"}, 32'(hits - h0), 32'(h));
  endtask
  initial begin
    chk("pin_first_bit", 32'(exp_at(0, 6'b101010, 6, 1, 1)), 32'b1110);
    chk("pin_second_bit", 32'(exp_at(0, 6'b101010, 6, 1, 2)), 32'b1010);
    chk("pin_gap_idle", 32'(exp_at(2, 6'b000101, 3, 3, 1 + 3 + PB)), 32'b1000);
    chk("pin_done", 32'(exp_at(0, 6'b101010, 6, 1, 7 + PB)), 32'b1001);
    repeat (3) @(negedge clk);
    chk("reset_state", {28'd0, ia.busy, ia.dout, ia.dout_valid, ia.done}, 32'd0);
    rst_n = 1'b1;
    go(6'b101010, 3'd6, 4'd1);
    wait_idle("frame");
    frame_chk("frame", PB ? 32'b1010101 : 32'b101010, 6 + PB, 1);
    go(6'b101010, 3'd6, 4'd2);
    wait_idle("reps2");
    frame_chk("reps2", PB ? 32'b10101011010101 : 32'b101010101010, 12 + 2 * PB, PB ? 2 : 4);
    go(6'b000101, 3'd3, 4'd3);
    wait_idle("short");
    frame_chk("short", PB ? 32'b101010101010 : 32'b101101101, 9 + 3 * PB, PB ? 4 : 0);
    go(6'b111111, 3'd0, 4'd1);
    repeat (4) @(negedge clk);
    chk("len0_busy", 32'(ia.busy), 32'd0);
    frame_chk("len0", 32'd0, 0, 0);
    go(6'b110011, 3'd6, 4'd1);
    repeat (2) @(negedge clk);
    pattern = 6'b000000;
    len = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    frame_chk("busy_start", PB ? 32'b1100110 : 32'b110011, 6 + PB, 0);
    go(6'b100111, 3'd7, 4'd1);
    wait_idle("clamp");
    frame_chk("clamp", PB ? 32'b1001110 : 32'b100111, 6 + PB, 0);
    go(6'b000010, 3'd2, 4'd0);
    wait_idle("reps0");
    frame_chk("reps0", PB ? 32'b101 : 32'b10, 2 + PB, 0);
    go(6'b101100, 3'd6, 4'd1);
    wait_idle("par");
    frame_chk("par", PB ? 32'b1011001 : 32'b101100, 6 + PB, 0);
    go(6'b101010, 3'd6, 4'd1);
    for (int n = 0; n < 50 && nbits - nb0 < 3; n++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_gap0", {28'd0, ia.busy, ia.dout, ia.dout_valid, ia.done}, 32'd0);
    chk("abort_gap2", {28'd0, ib.busy, ib.dout, ib.dout_valid, ib.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go(6'b101010, 3'd6, 4'd1);
    wait_idle("fresh");
    frame_chk("fresh", PB ? 32'b1010101 : 32'b101010, 6 + PB, 1);
    @(negedge clk);
    pattern = 6'b000001;
    len = 3'd2;
    reps = 4'd1;
    start = 1'b1;
    repeat (16) @(negedge clk);
    start = 1'b0;
    wait_idle("restart");
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
